// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up in a final cycle and MTHI/MTLO support.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] RsData,
  input  logic [WIDTH-1:0] RtData,
  input  logic             HiWrite,
  input  logic             LoWrite,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_opnd;
  logic [WIDTH-1:0]     r_rs_raw;
  logic [2*WIDTH-1:0]   r_p;
  logic                 r_is_div;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic                 r_div_zero;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_is_signed;
  logic                 w_sign_a;
  logic                 w_sign_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_sub;
  logic [WIDTH-1:0]     w_rem_new;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;

  // Op[0]=0 selects the signed variants; the most negative value keeps its own magnitude.
  assign w_is_signed = ~Op[0];
  assign w_sign_a    = w_is_signed & RsData[WIDTH-1];
  assign w_sign_b    = w_is_signed & RtData[WIDTH-1];
  assign w_mag_a     = w_sign_a ? -RsData : RsData;
  assign w_mag_b     = w_sign_b ? -RtData : RtData;

  // Multiply: r_p = {partial product, remaining multiplier bits}, r_opnd = multiplicand.
  assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};

  // Divide: r_p = {remainder, dividend shifting into quotient}, r_opnd = divisor.
  assign w_rem_sh   = r_p[2*WIDTH-1:WIDTH-1];
  assign w_ge       = w_rem_sh >= {1'b0, r_opnd};
  assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_opnd;
  assign w_rem_new  = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
  assign w_div_next = {w_rem_new, r_p[WIDTH-2:0], w_ge};

  assign w_prod = (r_sign_a ^ r_sign_b) ? -r_p : r_p;
  assign w_quot = (r_sign_a ^ r_sign_b) ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem  = r_sign_a ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_rs_raw   <= '0;
      r_p        <= '0;
      r_is_div   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_div_zero <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state    <= S_CALC;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_is_div   <= Op[1];
            r_sign_a   <= w_sign_a;
            r_sign_b   <= w_sign_b;
            r_rs_raw   <= RsData;
            r_div_zero <= Op[1] && (RtData == '0);
            r_opnd     <= Op[1] ? w_mag_b : w_mag_a;
            r_p        <= {{WIDTH{1'b0}}, (Op[1] ? w_mag_a : w_mag_b)};
          end else begin
            if (HiWrite) r_hi <= RsData;
            if (LoWrite) r_lo <= RsData;
          end
        end
        S_CALC: begin
          r_p <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          // Divide by zero returns the raw dividend, bypassing sign correction.
          if (r_div_zero) begin
            r_hi <= r_rs_raw;
            r_lo <= '1;
          end else if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Hi   = r_hi;
  assign Lo   = r_lo;
  assign Busy = r_busy;
  assign Done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, randomized ops against
// an arithmetic reference model, and hand sequences for busy/reset/MTHI corner cases.
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        HiWrite;
  logic        LoWrite;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op),
    .RsData(RsData), .RtData(RtData), .HiWrite(HiWrite), .LoWrite(LoWrite),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic, {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  return sa * sb;
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Called at a negedge; returns just after the Start edge with operands scrambled.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start  = 1'b1;
    Op     = op;
    RsData = a;
    RtData = b;
    @(posedge clk);
    #1;
    Start  = 1'b0;
    RsData = $urandom;
    RtData = $urandom;
  endtask

  // Returns at the negedge where Done is high.
  task automatic wait_result(input string tag, input logic [31:0] eh, input logic [31:0] el,
                             input int disturb);
    int busy_n = 0;
    bit seen = 0;
    bit held = 1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (k == disturb + 1) begin
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
      end
      if (Done) seen = 1;
      else begin
        if (Busy) busy_n++;
        if (Hi !== prev_hi || Lo !== prev_lo) held = 0;
      end
      if (!seen && k == disturb) begin
        Start = 1'b1; Op = OP_MULTU; HiWrite = 1'b1; LoWrite = 1'b1;
        RsData = $urandom; RtData = $urandom;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    check({tag, "_hold"}, 64'(held), 64'd1);
    check({tag, "_hi"}, 64'(Hi), 64'(eh));
    check({tag, "_lo"}, 64'(Lo), 64'(el));
    check({tag, "_busy_at_done"}, 64'(Busy), 64'd0);
    $display("txn %s: hi=%h lo=%h (exp hi=%h lo=%h) busy_cycles=%0d", tag, Hi, Lo, eh, el, busy_n);
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    logic [63:0] exp64;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    int done_n;

    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{OP_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
    vecs[5] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[6] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7] = '{OP_DIV,   32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
    vecs[8] = '{OP_MULTU, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E};

    rst = 1'b1; Start = 1'b0; Op = 2'b00; RsData = '0; RtData = '0;
    HiWrite = 1'b0; LoWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(Hi), 64'd0);
    check("reset_lo", 64'(Lo), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);

    // Directed table, each op issued in the Done cycle of the previous one.
    start_op(vecs[0].op, vecs[0].a, vecs[0].b);
    for (int i = 0; i < 9; i++) begin
      wait_result($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, -1);
      if (i < 8) start_op(vecs[i+1].op, vecs[i+1].a, vecs[i+1].b);
    end
    @(negedge clk);
    check("done_single_pulse", 64'(Done), 64'd0);

    // MTHI / MTLO in IDLE
    HiWrite = 1'b1; RsData = 32'h1234_5678;
    @(posedge clk); #1 HiWrite = 1'b0;
    @(negedge clk);
    check("mthi_hi", 64'(Hi), 64'h1234_5678);
    check("mthi_lo_unchanged", 64'(Lo), 64'(prev_lo));
    LoWrite = 1'b1; RsData = 32'hCAFE_F00D;
    @(posedge clk); #1 LoWrite = 1'b0;
    @(negedge clk);
    check("mtlo_lo", 64'(Lo), 64'hCAFE_F00D);
    check("mtlo_hi_unchanged", 64'(Hi), 64'h1234_5678);
    prev_hi = 32'h1234_5678;
    prev_lo = 32'hCAFE_F00D;

    // Start and HiWrite together: write dropped
    HiWrite = 1'b1;
    start_op(OP_MULTU, 32'd3, 32'd4);
    HiWrite = 1'b0;
    check("start_beats_mthi", 64'(Hi), 64'h1234_5678);
    wait_result("start_mthi", 32'd0, 32'd12, -1);

    // Start and HiWrite/LoWrite while busy are ignored
    @(negedge clk);
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_result("busy_ignore", 32'd2, 32'd14, 5);
    @(negedge clk);
    check("no_queue_busy", 64'(Busy), 64'd0);
    check("no_queue_done", 64'(Done), 64'd0);

    // Reset mid-operation
    start_op(OP_MULT, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_hi", 64'(Hi), 64'd0);
    check("midrst_lo", 64'(Lo), 64'd0);
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_done", 64'(Done), 64'd0);
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (Done) done_n++;
    end
    check("midrst_no_done", 64'(done_n), 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    start_op(OP_MULTU, 32'd5, 32'd6);
    wait_result("after_rst", 32'd0, 32'h1E, -1);

    // Randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: ra = 32'h0;
        1: ra = 32'h8000_0000;
        2: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h1;
        default: rb = $urandom;
      endcase
      exp64 = ref_model(rop, ra, rb);
      start_op(rop, ra, rb);
      wait_result($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), exp64[63:32], exp64[31:0], -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
